// File: rtl/sqemux_sel_seq_if.sv
// Select-request and source-enable bundle between the QCK control logic and the
// clock-select sequencer.
interface sqemux_sel_seq_if #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned SEL_W = $clog2(N_SRC)
);
  logic [SEL_W-1:0] SEL_REQ;
  logic             REQ_VLD;
  logic             REQ_RDY;
  logic             DYNEN;
  logic             SEN;
  logic             DEN;
  logic [N_SRC-1:0] SRC_EN;
  logic [SEL_W-1:0] SEL_CUR;
  logic             BUSY;
  logic             DONE;
  logic             ERR;

  modport master (
    output SEL_REQ, REQ_VLD, DYNEN, SEN, DEN,
    input  REQ_RDY, SRC_EN, SEL_CUR, BUSY, DONE, ERR
  );

  modport slave (
    input  SEL_REQ, REQ_VLD, DYNEN, SEN, DEN,
    output REQ_RDY, SRC_EN, SEL_CUR, BUSY, DONE, ERR
  );
endinterface

// File: rtl/sqemux_sel_seq.sv
// N-source clock-select sequencer: break-before-make switching of one-hot source
// enables, with a registered static/force-disable gate on the enable outputs.
module sqemux_sel_seq #(
  parameter int unsigned N_SRC   = 4,
  parameter int unsigned SEL_W   = $clog2(N_SRC),
  parameter int unsigned GAP     = 2,
  parameter int unsigned RST_SRC = 0
) (
  input  logic             QCK,
  input  logic             QRN,
  sqemux_sel_seq_if.slave  bus
);

  localparam int unsigned CNT_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [SEL_W:0]   N_LIM  = (SEL_W+1)'(N_SRC);
  localparam logic [N_SRC-1:0] RST_OH = N_SRC'(1) << RST_SRC;

  if (GAP < 1) begin : g_bad_gap
    $error("sqemux_sel_seq: GAP must be at least 1");
  end
  if (RST_SRC >= N_SRC) begin : g_bad_rst_src
    $error("sqemux_sel_seq: RST_SRC must be below N_SRC");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    ARM   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] tgt_q, tgt_d;
  logic [SEL_W-1:0] cur_q, cur_d;
  logic [N_SRC-1:0] en_q, en_d;
  logic             gate_q, gate_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic rdy_c;
  logic accept_c;
  logic bad_sel_c;

  assign rdy_c     = bus.DYNEN & (state_q == IDLE);
  assign accept_c  = bus.REQ_VLD & rdy_c;
  assign bad_sel_c = {1'b0, bus.SEL_REQ} >= N_LIM;

  // Next-state: enables drop to zero on accept and the new source arms after GAP dead cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    cur_d   = cur_q;
    en_d    = en_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    gate_d  = bus.SEN & ~bus.DEN;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (bad_sel_c) begin
            err_d = 1'b1;
          end else if (bus.SEL_REQ == cur_q) begin
            done_d = 1'b1;
          end else begin
            tgt_d   = bus.SEL_REQ;
            en_d    = '0;
            cnt_d   = CNT_W'(GAP - 1);
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = ARM;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ARM: begin
        en_d    = N_SRC'(1) << tgt_q;
        cur_d   = tgt_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge QCK or negedge QRN) begin
    if (!QRN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= SEL_W'(RST_SRC);
      cur_q   <= SEL_W'(RST_SRC);
      en_q    <= RST_OH;
      gate_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      cur_q   <= cur_d;
      en_q    <= en_d;
      gate_q  <= gate_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Ready is held low while reset is asserted even though the FSM rests in IDLE.
  assign bus.REQ_RDY = rdy_c & QRN;
  assign bus.SRC_EN  = en_q & {N_SRC{gate_q}};
  assign bus.SEL_CUR = cur_q;
  assign bus.BUSY    = (state_q != IDLE);
  assign bus.DONE    = done_q;
  assign bus.ERR     = err_q;

endmodule

// File: tb/tb_sqemux_sel_seq.sv
// Directed bench for sqemux_sel_seq: a 4-source build for the main sequences and a
// 6-source build for out-of-range request handling.
module tb_sqemux_sel_seq;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  sqemux_sel_seq_if #(.N_SRC(4)) bus4 ();
  sqemux_sel_seq_if #(.N_SRC(6)) bus6 ();

  sqemux_sel_seq #(.N_SRC(4), .GAP(2), .RST_SRC(0)) dut4 (
    .QCK (clk),
    .QRN (rst_n),
    .bus (bus4)
  );

  sqemux_sel_seq #(.N_SRC(6), .GAP(2), .RST_SRC(0)) dut6 (
    .QCK (clk),
    .QRN (rst_n),
    .bus (bus6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus4.SEL_REQ = '0; bus4.REQ_VLD = 1'b0; bus4.DYNEN = 1'b1; bus4.SEN = 1'b1; bus4.DEN = 1'b0;
    bus6.SEL_REQ = '0; bus6.REQ_VLD = 1'b0; bus6.DYNEN = 1'b1; bus6.SEN = 1'b1; bus6.DEN = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_src_en",  bus4.SRC_EN,  4'b0000);
    chk("rst_sel_cur", bus4.SEL_CUR, 0);
    chk("rst_rdy",     bus4.REQ_RDY, 0);
    chk("rst_busy",    bus4.BUSY,    0);
    chk("rst_done",    bus4.DONE,    0);
    chk("rst_err",     bus4.ERR,     0);

    // Release: gate opens on the first edge
    rst_n = 1'b1;
    #1;
    chk("rel_c0_src_en", bus4.SRC_EN,  4'b0000);
    chk("rel_c0_rdy",    bus4.REQ_RDY, 1);
    tick();
    chk("rel_c1_src_en", bus4.SRC_EN,  4'b0001);
    chk("rel_c1_sel_cur", bus4.SEL_CUR, 0);

    // No-op request 0 -> 0
    bus4.SEL_REQ = 2'd0; bus4.REQ_VLD = 1'b1;
    tick();
    bus4.REQ_VLD = 1'b0;
    chk("noop0_done",   bus4.DONE,   1);
    chk("noop0_busy",   bus4.BUSY,   0);
    chk("noop0_src_en", bus4.SRC_EN, 4'b0001);

    // Switch 0 -> 2
    bus4.SEL_REQ = 2'd2; bus4.REQ_VLD = 1'b1;
    tick();
    bus4.REQ_VLD = 1'b0;
    chk("sw2_c1_src_en", bus4.SRC_EN,  4'b0000);
    chk("sw2_c1_busy",   bus4.BUSY,    1);
    chk("sw2_c1_rdy",    bus4.REQ_RDY, 0);
    chk("sw2_c1_done",   bus4.DONE,    0);
    tick();
    chk("sw2_c2_src_en", bus4.SRC_EN, 4'b0000);
    chk("sw2_c2_busy",   bus4.BUSY,   1);
    tick();
    chk("sw2_c3_src_en", bus4.SRC_EN, 4'b0000);
    chk("sw2_c3_busy",   bus4.BUSY,   1);
    chk("sw2_c3_done",   bus4.DONE,   0);
    tick();
    chk("sw2_c4_src_en",  bus4.SRC_EN,  4'b0100);
    chk("sw2_c4_done",    bus4.DONE,    1);
    chk("sw2_c4_busy",    bus4.BUSY,    0);
    chk("sw2_c4_sel_cur", bus4.SEL_CUR, 2);
    tick();
    chk("sw2_c5_done",   bus4.DONE,   0);
    chk("sw2_c5_src_en", bus4.SRC_EN, 4'b0100);

    // No-op request 2 -> 2
    bus4.SEL_REQ = 2'd2; bus4.REQ_VLD = 1'b1;
    tick();
    bus4.REQ_VLD = 1'b0;
    chk("noop2_done",   bus4.DONE,   1);
    chk("noop2_busy",   bus4.BUSY,   0);
    chk("noop2_src_en", bus4.SRC_EN, 4'b0100);
    tick();
    chk("noop2_c2_done", bus4.DONE, 0);

    // DYNEN=0 freezes the select
    bus4.DYNEN = 1'b0; bus4.SEL_REQ = 2'd1; bus4.REQ_VLD = 1'b1;
    #1;
    chk("frz_rdy", bus4.REQ_RDY, 0);
    tick();
    tick();
    chk("frz_busy",    bus4.BUSY,    0);
    chk("frz_sel_cur", bus4.SEL_CUR, 2);
    chk("frz_done",    bus4.DONE,    0);
    bus4.REQ_VLD = 1'b0; bus4.DYNEN = 1'b1;

    // N_SRC=6 build: valid switch 0 -> 5, then out-of-range 7
    bus6.SEL_REQ = 3'd5; bus6.REQ_VLD = 1'b1;
    tick();
    bus6.REQ_VLD = 1'b0;
    chk("n6_c1_busy",   bus6.BUSY,   1);
    chk("n6_c1_src_en", bus6.SRC_EN, 6'b000000);
    tick();
    tick();
    tick();
    chk("n6_c4_src_en",  bus6.SRC_EN,  6'b100000);
    chk("n6_c4_sel_cur", bus6.SEL_CUR, 5);
    chk("n6_c4_done",    bus6.DONE,    1);
    bus6.SEL_REQ = 3'd7; bus6.REQ_VLD = 1'b1;
    tick();
    bus6.REQ_VLD = 1'b0;
    chk("n6_err",        bus6.ERR,     1);
    chk("n6_err_done",   bus6.DONE,    0);
    chk("n6_err_busy",   bus6.BUSY,    0);
    chk("n6_err_cur",    bus6.SEL_CUR, 5);
    chk("n6_err_src_en", bus6.SRC_EN,  6'b100000);
    tick();
    chk("n6_err_pulse", bus6.ERR, 0);

    // DEN asserted mid-switch 2 -> 3
    bus4.SEL_REQ = 2'd3; bus4.REQ_VLD = 1'b1;
    tick();
    bus4.REQ_VLD = 1'b0;
    tick();
    bus4.DEN = 1'b1;
    tick();
    chk("den_c3_busy", bus4.BUSY, 1);
    tick();
    chk("den_c4_done",    bus4.DONE,    1);
    chk("den_c4_sel_cur", bus4.SEL_CUR, 3);
    chk("den_c4_src_en",  bus4.SRC_EN,  4'b0000);
    bus4.DEN = 1'b0;
    #1;
    chk("den_rel_same_cyc", bus4.SRC_EN, 4'b0000);
    tick();
    chk("den_rel_next_cyc", bus4.SRC_EN, 4'b1000);

    // SEN gating, one cycle latency each way
    bus4.SEN = 1'b0;
    tick();
    chk("sen_off", bus4.SRC_EN, 4'b0000);
    bus4.SEN = 1'b1;
    tick();
    chk("sen_on", bus4.SRC_EN, 4'b1000);

    // Back-to-back: VLD held through a switch, second request accepted on the DONE edge
    bus4.SEL_REQ = 2'd0; bus4.REQ_VLD = 1'b1;
    tick();
    bus4.SEL_REQ = 2'd1;
    tick();
    tick();
    chk("b2b_c3_busy", bus4.BUSY, 1);
    tick();
    chk("b2b_c4_done",    bus4.DONE,    1);
    chk("b2b_c4_sel_cur", bus4.SEL_CUR, 0);
    chk("b2b_c4_src_en",  bus4.SRC_EN,  4'b0001);
    chk("b2b_c4_rdy",     bus4.REQ_RDY, 1);
    tick();
    bus4.REQ_VLD = 1'b0;
    chk("b2b_2nd_busy",   bus4.BUSY,   1);
    chk("b2b_2nd_src_en", bus4.SRC_EN, 4'b0000);
    tick();
    tick();
    tick();
    chk("b2b_2nd_done",    bus4.DONE,    1);
    chk("b2b_2nd_sel_cur", bus4.SEL_CUR, 1);
    chk("b2b_2nd_src_en",  bus4.SRC_EN,  4'b0010);

    // Reset during DRAIN discards the target
    bus4.SEL_REQ = 2'd2; bus4.REQ_VLD = 1'b1;
    tick();
    bus4.REQ_VLD = 1'b0;
    chk("mrst_pre_busy", bus4.BUSY, 1);
    rst_n = 1'b0;
    #2;
    chk("mrst_src_en",  bus4.SRC_EN,  4'b0000);
    chk("mrst_sel_cur", bus4.SEL_CUR, 0);
    chk("mrst_busy",    bus4.BUSY,    0);
    chk("mrst_rdy",     bus4.REQ_RDY, 0);
    tick();
    tick();
    tick();
    chk("mrst_no_done", bus4.DONE, 0);
    rst_n = 1'b1;
    tick();
    chk("mrst_rel_src_en",  bus4.SRC_EN,  4'b0001);
    chk("mrst_rel_sel_cur", bus4.SEL_CUR, 0);
    tick();
    tick();
    tick();
    chk("mrst_rel_done",   bus4.DONE,   0);
    chk("mrst_rel_src_en2", bus4.SRC_EN, 4'b0001);

    // Random request run: enables stay at most one-hot, DONE and ERR never coincide
    for (int i = 0; i < 300; i++) begin
      bus4.SEL_REQ = 2'($urandom_range(0, 3));
      bus4.REQ_VLD = 1'($urandom_range(0, 1));
      bus4.DYNEN   = ($urandom_range(0, 7) != 0);
      bus4.SEN     = ($urandom_range(0, 7) != 0);
      bus4.DEN     = ($urandom_range(0, 7) == 0);
      tick();
      chk("rand_popcount_le1", ($countones(bus4.SRC_EN) <= 1) ? 32'd1 : 32'd0, 32'd1);
      chk("rand_done_err_excl", {31'd0, bus4.DONE & bus4.ERR}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
